// File: rtl/fifo_sync_param.sv
// Synchronous FIFO with fill count, almost flags, sticky error flags and flush.
// Define FIFO_REG_OUT_EN for a registered read port (1-cycle latency).
module fifo_sync_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 5,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              iflush,
    input  logic              iwr,
    input  logic              ird,
    input  logic [DATA_W-1:0] iw_data,
    output logic [DATA_W-1:0] or_data,
    output logic              ofull,
    output logic              oempty,
    output logic              oalmost_full,
    output logic              oalmost_empty,
    output logic [ADDR_W:0]   ocount,
    output logic              ooverflow,
    output logic              ounderflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] rptr_q, rptr_d;
    logic [ADDR_W:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            full, empty;
    logic            wr_acc, rd_acc;
    logic            mem_we;
    logic [ADDR_W-1:0] waddr, raddr;

    assign waddr = wptr_q[ADDR_W-1:0];
    assign raddr = rptr_q[ADDR_W-1:0];

    // Status is decoded from the count register only, never from iwr/ird.
    assign full          = (count_q == DEPTH_C);
    assign empty         = (count_q == '0);
    assign ofull         = full;
    assign oempty        = empty;
    assign oalmost_full  = (count_q >= AF_C);
    assign oalmost_empty = (count_q <= AE_C);
    assign ocount        = count_q;
    assign ooverflow     = ovf_q;
    assign ounderflow    = unf_q;

    assign wr_acc = iwr & ~full;
    assign rd_acc = ird & ~empty;
    assign mem_we = wr_acc & ~iflush & ireset_n;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (iflush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) rptr_d = rptr_q + 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (iwr & full);
            unf_d = unf_q | (ird & empty);
        end
    end

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge iclk) begin
        if (mem_we) mem_q[waddr] <= iw_data;
    end

`ifdef FIFO_REG_OUT_EN
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (!iflush && rd_acc) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge iclk) begin
        if (!ireset_n) rdata_q <= '0;
        else           rdata_q <= rdata_d;
    end

    assign or_data = rdata_q;
`else
    // Show-ahead: head word is visible without a read strobe.
    assign or_data = mem_q[raddr];
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed and random scoreboard bench for fifo_sync_param (default parameters).
module tb_fifo_sync_param;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          iclk = 1'b0;
    logic          ireset_n;
    logic          iflush;
    logic          iwr;
    logic          ird;
    logic [DW-1:0] iw_data;
    logic [DW-1:0] or_data;
    logic          ofull, oempty, oalmost_full, oalmost_empty;
    logic [AW:0]   ocount;
    logic          ooverflow, ounderflow;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sb_q [$];
    bit            m_ovf, m_unf;
    logic [DW-1:0] m_rdata;

    fifo_sync_param #(
        .DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(28), .AE_LEVEL(4)
    ) dut (
        .iclk(iclk), .ireset_n(ireset_n), .iflush(iflush),
        .iwr(iwr), .ird(ird), .iw_data(iw_data), .or_data(or_data),
        .ofull(ofull), .oempty(oempty),
        .oalmost_full(oalmost_full), .oalmost_empty(oalmost_empty),
        .ocount(ocount), .ooverflow(ooverflow), .ounderflow(ounderflow)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        int n;
        n = sb_q.size();
        chk("count", 32'(ocount), 32'(n));
        chk("empty", 32'(oempty), 32'(n == 0));
        chk("full", 32'(ofull), 32'(n == DEPTH));
        chk("almost_full", 32'(oalmost_full), 32'(n >= 28));
        chk("almost_empty", 32'(oalmost_empty), 32'(n <= 4));
        chk("overflow", 32'(ooverflow), 32'(m_ovf));
        chk("underflow", 32'(ounderflow), 32'(m_unf));
`ifdef FIFO_REG_OUT_EN
        chk("rdata_reg", 32'(or_data), 32'(m_rdata));
`endif
    endtask

    // Called at a negedge: drive, check show-ahead data, clock, update model, check.
    task automatic step(input bit wr, input bit rd, input bit fl,
                        input bit rst, input logic [DW-1:0] d);
        bit wacc, racc, full_m, empty_m;
        logic [DW-1:0] rv;
        ireset_n = rst; iflush = fl; iwr = wr; ird = rd; iw_data = d;
        full_m  = (sb_q.size() == DEPTH);
        empty_m = (sb_q.size() == 0);
        wacc = rst && !fl && wr && !full_m;
        racc = rst && !fl && rd && !empty_m;
        #1;
`ifndef FIFO_REG_OUT_EN
        if (racc) chk("rdata_comb", 32'(or_data), 32'(sb_q[0]));
`endif
        @(posedge iclk);
        if (!rst) begin
            sb_q.delete(); m_ovf = 0; m_unf = 0; m_rdata = '0;
        end else if (fl) begin
            sb_q.delete(); m_ovf = 0; m_unf = 0;
        end else begin
            if (racc) begin
                rv = sb_q.pop_front();
                m_rdata = rv;
            end
            if (wacc) sb_q.push_back(d);
            if (wr && full_m)  m_ovf = 1;
            if (rd && empty_m) m_unf = 1;
        end
        @(negedge iclk);
        chk_status();
    endtask

    initial begin
        m_ovf = 0; m_unf = 0; m_rdata = '0;
        ireset_n = 1'b0; iflush = 1'b0; iwr = 1'b1; ird = 1'b0;
        iw_data = 16'hA5A5;
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        chk_status();
        ireset_n = 1'b1; iwr = 1'b0;

        // Fill with 0..31, then reject 0xBEEF while full.
        for (int i = 0; i < 32; i++) step(1, 0, 0, 1, 16'(i));
        step(1, 0, 0, 1, 16'hBEEF);
        // Drain in order, then underflow on empty.
        for (int i = 0; i < 32; i++) step(0, 1, 0, 1, '0);
        step(0, 1, 0, 1, '0);
        step(0, 0, 1, 1, '0);

        // Empty + simultaneous access: write only, underflow sets.
        step(1, 1, 0, 1, 16'h1234);
        step(0, 1, 0, 1, '0);

        // Full + simultaneous access: read only, overflow sets.
        for (int i = 0; i < 32; i++) step(1, 0, 0, 1, 16'h0200 + 16'(i));
        step(1, 1, 0, 1, 16'hCAFE);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 1, '0);

        // Half full, streaming across pointer wrap.
        for (int i = 0; i < 100; i++) step(1, 1, 0, 1, 16'h0400 + 16'(i));

        // Down to 10 words with overflow still set, then flush with a write.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 1, '0);
        step(1, 0, 1, 1, 16'hDEAD);
        step(0, 0, 0, 1, '0);

        // Random traffic with occasional flush and one mid-burst reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 2), (i != 200),
                 16'($urandom));
        end
        for (int i = 0; i < 34; i++) step(0, 1, 0, 1, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
